// File: rtl/systolic_cmd_sequencer.sv
// Bus initiator that programs one systolic matrix operation through the 8-bit
// CPU register interface, pulses start, polls status and returns a response.
// Latency: 8 write cycles after the accept edge, then one status read every
// POLL_GAP+2 cycles. All bus strobes are gated by bus_ready. The response
// holds until rsp_ready. cmd_ready is high only in IDLE.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/ready, cmd_*        descriptor handshake and fields
//   bus_addr/_read_enable/_write_enable/_write_data/_read_data/_ready
//                                 register bus towards the systolic system
//   rsp_valid/ready, rsp_error/_status/_polls
//                                 completion record
//   busy                          high whenever not IDLE
module systolic_cmd_sequencer #(
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT_POLLS = 1024,
  parameter int POLL_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_rows,
  input  logic [3:0]        cmd_cols,
  input  logic [7:0]        cmd_base_a,
  input  logic [7:0]        cmd_base_b,
  input  logic [7:0]        cmd_base_c,
  output logic [7:0]        bus_addr,
  output logic              bus_read_enable,
  output logic              bus_write_enable,
  output logic [7:0]        bus_write_data,
  input  logic [7:0]        bus_read_data,
  input  logic              bus_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_error,
  output logic [7:0]        rsp_status,
  output logic [POLL_W-1:0] rsp_polls,
  output logic              busy
);

  localparam int GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  typedef enum logic [3:0] {
    IDLE, WR_OP, WR_ROWS, WR_COLS, WR_A, WR_B, WR_C,
    WR_START, WR_CLEAR, GAP, RD_REQ, RD_WAIT, RESP
  } state_t;

  // With no gap configured the poll loop goes straight back to the read.
  localparam state_t POLL_NEXT = (POLL_GAP == 0) ? RD_REQ : GAP;

  state_t              r_state;
  state_t              w_next;

  logic [1:0]          r_op;
  logic [3:0]          r_rows;
  logic [3:0]          r_cols;
  logic [7:0]          r_base_a;
  logic [7:0]          r_base_b;
  logic [7:0]          r_base_c;
  logic [POLL_W-1:0]   r_polls;
  logic [GAP_W-1:0]    r_gap;
  logic                r_seen_busy;
  logic [7:0]          r_status;
  logic                r_error;

  logic [7:0]          w_addr;
  logic [7:0]          w_wdata;
  logic                w_is_wr;
  logic                w_accept;
  logic                w_sample;
  logic                w_gap_done;
  logic [POLL_W-1:0]   w_polls_inc;
  logic                w_success;
  logic                w_timeout;

  assign w_accept    = (r_state == IDLE) && cmd_valid;
  assign w_sample    = (r_state == RD_WAIT) && bus_ready;
  assign w_gap_done  = (r_gap == GAP_W'(GAP_LAST));
  // Saturate rather than wrap so a huge count never looks small.
  assign w_polls_inc = (r_polls == {POLL_W{1'b1}}) ? r_polls : r_polls + POLL_W'(1);
  // Done bit wins; otherwise busy falling after having been seen high means
  // the one-cycle done pulse was missed between polls.
  assign w_success   = bus_read_data[1] | (~bus_read_data[0] & r_seen_busy);
  assign w_timeout   = ~w_success & (w_polls_inc >= POLL_W'(TIMEOUT_POLLS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_addr  = 8'h00;
    w_wdata = 8'h00;
    w_is_wr = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) w_next = WR_OP;
      end
      WR_OP: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h02;
        w_wdata = {6'b0, r_op};
        if (bus_ready) w_next = WR_ROWS;
      end
      WR_ROWS: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h03;
        w_wdata = {4'b0, r_rows};
        if (bus_ready) w_next = WR_COLS;
      end
      WR_COLS: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h04;
        w_wdata = {4'b0, r_cols};
        if (bus_ready) w_next = WR_A;
      end
      WR_A: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h05;
        w_wdata = r_base_a;
        if (bus_ready) w_next = WR_B;
      end
      WR_B: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h06;
        w_wdata = r_base_b;
        if (bus_ready) w_next = WR_C;
      end
      WR_C: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h07;
        w_wdata = r_base_c;
        if (bus_ready) w_next = WR_START;
      end
      WR_START: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h00;
        w_wdata = 8'h01;
        if (bus_ready) w_next = WR_CLEAR;
      end
      // Dropping start right away keeps the engine from re-triggering once
      // it finishes and deasserts busy.
      WR_CLEAR: begin
        w_is_wr = 1'b1;
        w_addr  = 8'h00;
        w_wdata = 8'h00;
        if (bus_ready) w_next = POLL_NEXT;
      end
      GAP: begin
        w_addr = 8'h01;
        if (w_gap_done) w_next = RD_REQ;
      end
      RD_REQ: begin
        w_addr = 8'h01;
        if (bus_ready) w_next = RD_WAIT;
      end
      RD_WAIT: begin
        w_addr = 8'h01;
        if (bus_ready) begin
          if (w_success || w_timeout) w_next = RESP;
          else                        w_next = POLL_NEXT;
        end
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= 2'd0;
      r_rows      <= 4'd0;
      r_cols      <= 4'd0;
      r_base_a    <= 8'h00;
      r_base_b    <= 8'h00;
      r_base_c    <= 8'h00;
      r_polls     <= '0;
      r_gap       <= '0;
      r_seen_busy <= 1'b0;
      r_status    <= 8'h00;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op        <= cmd_op;
        r_rows      <= cmd_rows;
        r_cols      <= cmd_cols;
        r_base_a    <= cmd_base_a;
        r_base_b    <= cmd_base_b;
        r_base_c    <= cmd_base_c;
        r_polls     <= '0;
        r_gap       <= '0;
        r_seen_busy <= 1'b0;
        r_status    <= 8'h00;
        r_error     <= 1'b0;
      end
      if (r_state == GAP) begin
        r_gap <= w_gap_done ? '0 : r_gap + GAP_W'(1);
      end
      if (w_sample) begin
        r_status <= bus_read_data;
        r_polls  <= w_polls_inc;
        r_error  <= w_timeout;
        if (bus_read_data[0]) r_seen_busy <= 1'b1;
      end
    end
  end

  assign cmd_ready        = (r_state == IDLE);
  assign busy             = (r_state != IDLE);
  assign bus_addr         = w_addr;
  assign bus_write_data   = w_wdata;
  assign bus_write_enable = w_is_wr & bus_ready;
  assign bus_read_enable  = (r_state == RD_REQ) & bus_ready;
  assign rsp_valid        = (r_state == RESP);
  assign rsp_error        = r_error;
  assign rsp_status       = r_status;
  assign rsp_polls        = r_polls;

endmodule

// File: tb/tb_systolic_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_systolic_cmd_sequencer;

  localparam int POLL_GAP      = 4;
  localparam int TIMEOUT_POLLS = 8;
  localparam int POLL_W        = 16;
  localparam int RD_PERIOD     = POLL_GAP + 2;
  localparam int FIRST_RD      = 9 + POLL_GAP;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [3:0]        cmd_rows = 4'd0;
  logic [3:0]        cmd_cols = 4'd0;
  logic [7:0]        cmd_base_a = 8'h00;
  logic [7:0]        cmd_base_b = 8'h00;
  logic [7:0]        cmd_base_c = 8'h00;
  logic [7:0]        bus_addr;
  logic              bus_read_enable;
  logic              bus_write_enable;
  logic [7:0]        bus_write_data;
  logic [7:0]        bus_read_data = 8'hA5;
  logic              bus_ready = 1'b1;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_error;
  logic [7:0]        rsp_status;
  logic [POLL_W-1:0] rsp_polls;
  logic              busy;

  always #5 clk = ~clk;

  systolic_cmd_sequencer #(
    .POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TIMEOUT_POLLS), .POLL_W(POLL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_base_c(cmd_base_c),
    .bus_addr(bus_addr), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_ready(bus_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
    .rsp_status(rsp_status), .rsp_polls(rsp_polls), .busy(busy)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [63:0] st;     // status bytes the responder returns, byte 0 first
    int          nst;
    logic        err;
    logic [7:0]  est;
    int          epolls;
    int          hold;   // cycles to hold rsp_ready low while response waits
  } vec_t;

  wr_t        wr_q[$];
  logic [7:0] st_q[$];
  vec_t       vecs[8];

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc = 0;
  int   accept_cyc = -1;
  int   first_wr_cyc = -1;
  int   last_wr_cyc = -1;
  int   first_rd_cyc = -1;
  int   prev_rd_cyc = -1;
  int   rd_cnt = 0;
  int   wr06_cnt = 0;
  int   rd_gap_bad = 0;
  int   strobe_cnt = 0;
  bit   rd_pending = 1'b0;
  bit   manual_rd = 1'b0;
  logic [7:0] manual_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus responder + scoreboard, sampled mid-cycle after the negedge.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (cmd_valid && cmd_ready) begin
      accept_cyc   = cyc;
      first_wr_cyc = -1;
      last_wr_cyc  = -1;
      first_rd_cyc = -1;
      rd_cnt       = 0;
      wr06_cnt     = 0;
      rd_gap_bad   = 0;
    end
    // Read data appears the cycle after the strobe and is held until the next read.
    if (manual_rd) begin
      bus_read_data = manual_val;
    end else if (rd_pending) begin
      bus_read_data = (st_q.size() > 0) ? st_q.pop_front() : 8'h00;
    end
    rd_pending = 1'b0;
    if (bus_write_enable && bus_read_enable) check("both_strobes", 1, 0);
    if (bus_write_enable) begin
      wr_t w;
      strobe_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (bus_addr == 8'h06) wr06_cnt++;
      if (wr_q.size() == 0) begin
        check("unexpected_write_addr", {24'h0, bus_addr}, 32'hFFFF);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", {24'h0, bus_addr}, {24'h0, w.addr});
        check("wr_data", {24'h0, bus_write_data}, {24'h0, w.data});
      end
    end
    if (bus_read_enable) begin
      strobe_cnt++;
      rd_cnt++;
      if (bus_addr != 8'h01) check("rd_addr", {24'h0, bus_addr}, 32'h01);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      else if (cyc - prev_rd_cyc != RD_PERIOD) rd_gap_bad++;
      prev_rd_cyc = cyc;
      rd_pending  = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_writes(input logic [1:0] op, input logic [3:0] r, input logic [3:0] c,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] cc);
    wr_q.push_back('{8'h02, {6'b0, op}});
    wr_q.push_back('{8'h03, {4'b0, r}});
    wr_q.push_back('{8'h04, {4'b0, c}});
    wr_q.push_back('{8'h05, a});
    wr_q.push_back('{8'h06, b});
    wr_q.push_back('{8'h07, cc});
    wr_q.push_back('{8'h00, 8'h01});
    wr_q.push_back('{8'h00, 8'h00});
  endtask

  // Called at negedge+1 while IDLE; returns at negedge+1 of the first WR_OP cycle.
  task automatic issue_cmd(input logic [1:0] op, input logic [3:0] r, input logic [3:0] c,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] cc);
    cmd_op = op; cmd_rows = r; cmd_cols = c;
    cmd_base_a = a; cmd_base_b = b; cmd_base_c = cc;
    cmd_valid = 1'b1;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    // Scrambled fields must not reach the bus.
    cmd_op = ~op; cmd_rows = ~r; cmd_cols = ~c;
    cmd_base_a = ~a; cmd_base_b = ~b; cmd_base_c = ~cc;
  endtask

  task automatic wait_rsp(output bit seen);
    int k;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 600) begin
      @(negedge clk); #1;
      k++;
      seen = rsp_valid;
    end
  endtask

  task automatic recover();
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    wr_q.delete();
    st_q.delete();
    rsp_ready = 1'b0;
    bus_ready = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit seen;
    @(negedge clk); #1;
    check($sformatf("v%0d_cmd_ready_idle", idx), cmd_ready, 1);
    push_writes(v.op, v.rows, v.cols, v.a, v.b, v.c);
    for (int i = 0; i < v.nst; i++) st_q.push_back(v.st[8*i +: 8]);
    rsp_ready = (v.hold == 0);
    issue_cmd(v.op, v.rows, v.cols, v.a, v.b, v.c);
    wait_rsp(seen);
    check($sformatf("v%0d_rsp_seen", idx), seen, 1);
    if (!seen) begin
      recover();
      return;
    end
    check($sformatf("v%0d_rsp_error", idx), rsp_error, v.err);
    check($sformatf("v%0d_rsp_status", idx), rsp_status, v.est);
    check($sformatf("v%0d_rsp_polls", idx), rsp_polls, v.epolls);
    check($sformatf("v%0d_read_strobes", idx), rd_cnt, v.epolls);
    check($sformatf("v%0d_first_write_cyc", idx), first_wr_cyc - accept_cyc, 1);
    check($sformatf("v%0d_last_write_cyc", idx), last_wr_cyc - accept_cyc, 8);
    check($sformatf("v%0d_first_read_cyc", idx), first_rd_cyc - accept_cyc, FIRST_RD);
    check($sformatf("v%0d_read_spacing_bad", idx), rd_gap_bad, 0);
    check($sformatf("v%0d_writes_left", idx), wr_q.size(), 0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk); #1;
      check($sformatf("v%0d_hold_valid", idx), rsp_valid, 1);
      check($sformatf("v%0d_hold_cmd_ready", idx), cmd_ready, 0);
      check($sformatf("v%0d_hold_error", idx), rsp_error, v.err);
      check($sformatf("v%0d_hold_status", idx), rsp_status, v.est);
      check($sformatf("v%0d_hold_polls", idx), rsp_polls, v.epolls);
    end
    rsp_ready = 1'b1;
    if (v.hold > 0) begin
      @(negedge clk); #1;
    end else begin
      @(negedge clk); #1;
    end
    check($sformatf("v%0d_idle_after_rsp", idx), busy, 0);
    check($sformatf("v%0d_rsp_valid_cleared", idx), rsp_valid, 0);
    rsp_ready = 1'b0;
    st_q.delete();
  endtask

  initial begin
    bit seen;
    bit found;
    int k;
    int strobes_before;
    vec_t pv;

    //          op    rows  cols  A      B      C      statuses                nst err  status  polls hold
    vecs[0] = '{2'd1, 4'd4, 4'd3, 8'h10, 8'h20, 8'h30, 64'h0000_0000_0201_0101, 4, 1'b0, 8'h02, 4, 5};
    vecs[1] = '{2'd0, 4'd2, 4'd5, 8'hA1, 8'hB2, 8'hC3, 64'h0000_0000_0000_0101, 3, 1'b0, 8'h00, 3, 0};
    vecs[2] = '{2'd3, 4'hF, 4'hF, 8'hFF, 8'hEE, 8'hDD, 64'h0000_0000_0000_0000, 8, 1'b1, 8'h00, 8, 0};
    vecs[3] = '{2'd0, 4'd1, 4'd1, 8'h00, 8'h01, 8'h02, 64'h0000_0000_0000_0002, 1, 1'b0, 8'h02, 1, 2};
    vecs[4] = '{2'd1, 4'd8, 4'd7, 8'h55, 8'hAA, 8'h5A, 64'h0000_0000_0000_0100, 3, 1'b0, 8'h00, 3, 0};
    vecs[5] = '{2'd0, 4'd3, 4'd9, 8'h12, 8'h34, 8'h56, 64'h0200_0000_0000_0000, 8, 1'b0, 8'h02, 8, 0};
    vecs[6] = '{2'd1, 4'd6, 4'd2, 8'h9A, 8'hBC, 8'hDE, 64'h0101_0101_0101_0101, 8, 1'b1, 8'h01, 8, 1};
    vecs[7] = '{2'd0, 4'd5, 4'd4, 8'h40, 8'h50, 8'h60, 64'h0000_0000_0000_0301, 2, 1'b0, 8'h03, 2, 0};

    // Reset state
    @(negedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_en", bus_write_enable, 0);
    check("rst_rd_en", bus_read_enable, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_write_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_polls", rsp_polls, 0);
    @(negedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // bus_ready stalls in WR_B and in RD_WAIT
    manual_rd  = 1'b1;
    manual_val = 8'h00;
    @(negedge clk); #1;
    push_writes(2'd0, 4'd2, 4'd2, 8'h11, 8'h22, 8'h33);
    issue_cmd(2'd0, 4'd2, 4'd2, 8'h11, 8'h22, 8'h33);
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      if (bus_addr == 8'h06 && busy) found = 1'b1;
      else begin @(negedge clk); #1; k++; end
    end
    check("t5_reach_wr_b", found, 1);
    bus_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("t5_wrb_addr_hold", bus_addr, 8'h06);
      check("t5_wrb_no_strobe", bus_write_enable, 0);
    end
    bus_ready = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      @(negedge clk); #1; k++;
      found = bus_read_enable;
    end
    check("t5_reach_rd_req", found, 1);
    @(negedge clk); #1;
    bus_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("t5_rdw_addr_hold", bus_addr, 8'h01);
      check("t5_rdw_no_strobe", bus_read_enable, 0);
      check("t5_rdw_no_rsp", rsp_valid, 0);
    end
    manual_val = 8'h02;
    bus_ready  = 1'b1;
    wait_rsp(seen);
    check("t5_rsp_seen", seen, 1);
    check("t5_rsp_error", rsp_error, 0);
    check("t5_rsp_status", rsp_status, 8'h02);
    check("t5_rsp_polls", rsp_polls, 1);
    check("t5_read_strobes", rd_cnt, 1);
    check("t5_writes_to_06", wr06_cnt, 1);
    check("t5_writes_left", wr_q.size(), 0);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("t5_idle", busy, 0);
    rsp_ready = 1'b0;
    manual_rd = 1'b0;

    // Reset in the middle of GAP after one poll
    @(negedge clk); #1;
    push_writes(2'd1, 4'd7, 4'd7, 8'h77, 8'h88, 8'h99);
    st_q.push_back(8'h01); st_q.push_back(8'h01); st_q.push_back(8'h01);
    issue_cmd(2'd1, 4'd7, 4'd7, 8'h77, 8'h88, 8'h99);
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      @(negedge clk); #1; k++;
      found = bus_read_enable;
    end
    check("t6_reach_rd_req", found, 1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("t6_busy_in_gap", busy, 1);
    check("t6_polls_before_rst", rsp_polls, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_wr_en", bus_write_enable, 0);
    check("t6_rst_rd_en", bus_read_enable, 0);
    check("t6_rst_cmd_ready", cmd_ready, 1);
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_polls", rsp_polls, 0);
    check("t6_rst_busy", busy, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    st_q.delete();
    wr_q.delete();
    strobes_before = strobe_cnt;
    repeat (12) @(negedge clk);
    #1;
    check("t6_no_strobes_after_rst", strobe_cnt - strobes_before, 0);
    check("t6_still_idle", busy, 0);

    // Post-reset command: an early 0x00 must not look like busy falling
    pv = '{2'd0, 4'd9, 4'd1, 8'h0A, 8'h0B, 8'h0C, 64'h0000_0000_0000_0200, 2, 1'b0, 8'h02, 2, 0};
    run_vec(8, pv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
